// File: rtl/mem_pkg.sv
// Shared definitions for the 512x32 memory responder: FSM state encoding,
// default geometry and the wait-counter width helper.
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Counter only has to hold WAIT_CYCLES-1, so clog2(WAIT_CYCLES) bits suffice.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that stalls at zero; paces the WAIT state of the
// memory responder when MEM_WAIT_STATES_EN is defined.
module mem_wait_counter
    import mem_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_responder_512x32.sv
// Single-port 512x32 memory with request/ready handshake and bench preload port.
// Optional feature: define MEM_WAIT_STATES_EN to insert WAIT_CYCLES wait states.
module mem_responder_512x32
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Mem_enable512x32,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [ADDR_WIDTH-1:0] MAR_address,
    input  logic [DATA_WIDTH-1:0] Mem_data_in,
    output logic [DATA_WIDTH-1:0] Mem_data_out,
    output logic                  Mem_ready,
    output logic                  Mem_error,
    input  logic                  mem_overide,
    input  logic [ADDR_WIDTH-1:0] overide_address,
    input  logic [DATA_WIDTH-1:0] overide_data_in
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    mem_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_write;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_ready;
    logic                  r_error;

    logic                  w_idle;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_enter_done;
    logic                  w_commit;
    mem_state_e            w_first_state;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic                  w_acc_write;

    assign w_idle    = (r_state == IDLE);
    assign w_req     = w_idle && Mem_enable512x32 && !mem_overide;
    assign w_accept  = w_req && (Mem_Read ^ Mem_Write);
    assign w_illegal = w_req && Mem_Read && Mem_Write;

    // In IDLE the access completes off the live inputs; later it uses the latched copy.
    assign w_acc_addr  = w_idle ? MAR_address : r_addr;
    assign w_acc_wdata = w_idle ? Mem_data_in : r_wdata;
    assign w_acc_write = w_idle ? Mem_Write   : r_is_write;

`ifdef MEM_WAIT_STATES_EN
    if (WAIT_CYCLES > 0) begin : g_wait
        localparam int CW = cnt_width(WAIT_CYCLES);
        logic w_cnt_zero;

        mem_wait_counter #(
            .WIDTH(CW)
        ) u_wait_cnt (
            .i_clk      (Clock),
            .i_rst_n    (clear),
            .i_load     (w_accept),
            .i_load_val (CW'(WAIT_CYCLES - 1)),
            .i_dec      ((r_state == WAIT) && !mem_overide),
            .o_zero     (w_cnt_zero)
        );

        assign w_first_state = WAIT;
        assign w_enter_done  = (r_state == WAIT) && !mem_overide && w_cnt_zero;
    end else begin : g_no_wait
        assign w_first_state = DONE;
        assign w_enter_done  = w_accept;
    end
`else
    assign w_first_state = DONE;
    assign w_enter_done  = w_accept;
`endif

    assign w_commit = w_enter_done && w_acc_write && clear;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_dout     <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_ready <= w_enter_done;
            r_error <= w_illegal;
            if (w_enter_done && !w_acc_write) begin
                r_dout <= r_mem[w_acc_addr];
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr     <= MAR_address;
                        r_wdata    <= Mem_data_in;
                        r_is_write <= Mem_Write;
                        r_state    <= w_first_state;
                    end
                end
`ifdef MEM_WAIT_STATES_EN
                WAIT: begin
                    if (w_enter_done) begin
                        r_state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (!mem_overide) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Override is written last so it wins a same-address collision with a commit.
    always_ff @(posedge Clock) begin
        if (w_commit) begin
            r_mem[w_acc_addr] <= w_acc_wdata;
        end
        if (mem_overide) begin
            r_mem[overide_address] <= overide_data_in;
        end
    end

    assign Mem_data_out = r_dout;
    assign Mem_ready    = r_ready;
    assign Mem_error    = r_error;

endmodule

// File: tb/tb_mem_responder_512x32.sv
// Directed bench for mem_responder_512x32 with a transaction-level reference model
// checked every cycle; latency follows MEM_WAIT_STATES_EN when it is defined.
module tb_mem_responder_512x32;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WC = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int LAT = (WC > 0) ? WC + 1 : 1;
`else
    localparam int LAT = 1;
`endif

    logic          Clock = 1'b0;
    logic          clear = 1'b0;
    logic          en = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          ovr = 1'b0;
    logic [AW-1:0] ovr_addr = '0;
    logic [DW-1:0] ovr_din = '0;
    logic [DW-1:0] Mem_data_out;
    logic          Mem_ready;
    logic          Mem_error;

    mem_responder_512x32 #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .Clock            (Clock),
        .clear            (clear),
        .Mem_enable512x32 (en),
        .Mem_Read         (rd),
        .Mem_Write        (wr),
        .MAR_address      (addr),
        .Mem_data_in      (din),
        .Mem_data_out     (Mem_data_out),
        .Mem_ready        (Mem_ready),
        .Mem_error        (Mem_error),
        .mem_overide      (ovr),
        .overide_address  (ovr_addr),
        .overide_data_in  (ovr_din)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;
    int ready_seen = 0;
    bit chk_en = 1'b0;

    // Reference model: memory contents plus one outstanding transaction.
    logic [DW-1:0] m_mem [512];
    logic [DW-1:0] m_dout = '0;
    logic          m_ready = 1'b0;
    logic          m_err = 1'b0;
    int            m_phase = 0;   // 0 free, 1 in flight, 2 completion cycle
    int            m_left = 0;
    logic [AW-1:0] m_p_addr;
    logic [DW-1:0] m_p_data;
    logic          m_p_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0;
        m_left  = 0;
        m_dout  = '0;
        m_ready = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_update();
        if (!clear) begin
            model_reset();
        end else begin
            m_ready = 1'b0;
            m_err   = 1'b0;
            case (m_phase)
                0: if (en && !ovr) begin
                    if (rd && wr) begin
                        m_err = 1'b1;
                    end else if (rd ^ wr) begin
                        m_p_addr = addr;
                        m_p_data = din;
                        m_p_wr   = wr;
                        m_left   = LAT - 1;
                        m_phase  = 1;
                    end
                end
                1: if (!ovr) m_left--;
                2: if (!ovr) m_phase = 0;
                default: m_phase = 0;
            endcase
            if (m_phase == 1 && m_left == 0) begin
                if (m_p_wr) m_mem[m_p_addr] = m_p_data;
                else        m_dout = m_mem[m_p_addr];
                m_ready = 1'b1;
                m_phase = 2;
            end
        end
        if (ovr) m_mem[ovr_addr] = ovr_din;
    endfunction

    task automatic step();
        @(posedge Clock);
        model_update();
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ovr = 1'b1;
        ovr_addr = a;
        ovr_din = d;
        step();
        ovr = 1'b0;
    endtask

    task automatic access(input string name, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lat;
        en = 1'b1;
        rd = r;
        wr = w;
        addr = a;
        din = d;
        step();
        en = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        lat = 1;
        while (Mem_ready !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk(name, lat, LAT);
        step();
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            if (chk_en) begin
                chk("cyc_ready", Mem_ready, m_ready);
                chk("cyc_error", Mem_error, m_err);
                chk("cyc_dout", Mem_data_out, m_dout);
                if (Mem_ready === 1'b1) ready_seen++;
            end
        end
    end

    initial begin
        int r0;
        repeat (2) step();
        chk("rst_dout", Mem_data_out, 32'h0);
        chk("rst_ready", Mem_ready, 1'b0);
        chk("rst_error", Mem_error, 1'b0);
        clear = 1'b1;
        chk_en = 1'b1;

        preload(9'd0,   32'h18900001);
        preload(9'd500, 32'h00000014);
        preload(9'd7,   32'h0BADF00D);
        preload(9'd511, 32'h11111111);
        preload(9'd5,   32'h55555555);

        access("lat_rd0", 1'b1, 1'b0, 9'd0, '0);
        chk("rd0_data", Mem_data_out, 32'h18900001);
        access("lat_rd500", 1'b1, 1'b0, 9'd500, '0);
        chk("rd500_data", Mem_data_out, 32'h00000014);
        access("lat_wr511", 1'b0, 1'b1, 9'd511, 32'hDEADBEEF);
        chk("wr_keeps_dout", Mem_data_out, 32'h00000014);
        access("lat_rd511", 1'b1, 1'b0, 9'd511, '0);
        chk("rd511_data", Mem_data_out, 32'hDEADBEEF);

        // Both read and write asserted: error pulse only.
        r0 = ready_seen;
        en = 1'b1; rd = 1'b1; wr = 1'b1; addr = 9'd511; din = 32'hCAFEF00D;
        step();
        chk("err_pulse", Mem_error, 1'b1);
        chk("err_no_ready", Mem_ready, 1'b0);
        en = 1'b0; rd = 1'b0; wr = 1'b0;
        step();
        chk("err_clears", Mem_error, 1'b0);
        chk("err_no_ready_cnt", ready_seen - r0, 0);
        access("lat_rd511b", 1'b1, 1'b0, 9'd511, '0);
        chk("err_array_kept", Mem_data_out, 32'hDEADBEEF);

        // Request held continuously: accepted again in the first IDLE after DONE.
        r0 = ready_seen;
        en = 1'b1; rd = 1'b1; addr = 9'd500;
        repeat (2 * (LAT + 1)) step();
        en = 1'b0; rd = 1'b0;
        repeat (2) step();
        chk("b2b_pulses", ready_seen - r0, 2);

        // Override rewrites addr 5 while a read of addr 5 is pending.
        r0 = ready_seen;
        if (LAT > 1) begin
            en = 1'b1; rd = 1'b1; addr = 9'd5;
            step();
            en = 1'b0; rd = 1'b0;
            ovr = 1'b1; ovr_addr = 9'd5; ovr_din = 32'hA5A5A5A5;
            repeat (3) step();
            ovr = 1'b0;
        end else begin
            en = 1'b1; rd = 1'b1; addr = 9'd5;
            ovr = 1'b1; ovr_addr = 9'd5; ovr_din = 32'hA5A5A5A5;
            repeat (3) step();
            ovr = 1'b0;
            step();
            en = 1'b0; rd = 1'b0;
        end
        chk("ovr_no_ready", ready_seen - r0, 0);
        for (int i = 0; i < 20 && Mem_ready !== 1'b1; i++) step();
        chk("ovr_ready", Mem_ready, 1'b1);
        chk("ovr_rd_data", Mem_data_out, 32'hA5A5A5A5);
        step();

        // Reset during a write to addr 7 aborts it.
        r0 = ready_seen;
        if (LAT > 1) begin
            en = 1'b1; wr = 1'b1; addr = 9'd7; din = 32'h12345678;
            step();
            en = 1'b0; wr = 1'b0;
            clear = 1'b0;
            model_reset();
        end else begin
            en = 1'b1; wr = 1'b1; addr = 9'd7; din = 32'h12345678;
            clear = 1'b0;
            model_reset();
            step();
            en = 1'b0; wr = 1'b0;
        end
        #1;
        chk("abort_dout", Mem_data_out, 32'h0);
        chk("abort_ready", Mem_ready, 1'b0);
        repeat (3) step();
        clear = 1'b1;
        repeat (2) step();
        chk("abort_no_ready", ready_seen - r0, 0);
        access("lat_rd7", 1'b1, 1'b0, 9'd7, '0);
        chk("abort_addr7_kept", Mem_data_out, 32'h0BADF00D);

        repeat (2) step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder_512x32.md
MEM_RESPONDER_512X32 -- requirements
Module: mem_responder_512x32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word address width (512 words).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, extra access cycles; used only under MEM_WAIT_STATES_EN.
REQ-004 SHALL have port Clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port Mem_enable512x32, input, 1, request qualifier from datapath.
REQ-007 SHALL have ports Mem_Read and Mem_Write, input, 1 each, access type.
REQ-008 SHALL have port MAR_address, input, ADDR_WIDTH, word address from MAR.
REQ-009 SHALL have port Mem_data_in, input, DATA_WIDTH, write data from MDR.
REQ-010 SHALL have port Mem_data_out, output, DATA_WIDTH, read data to MDR.
REQ-011 SHALL have port Mem_ready, output, 1, one-cycle access-complete pulse.
REQ-012 SHALL have port Mem_error, output, 1, one-cycle pulse on an illegal request.
REQ-013 SHALL have ports mem_overide (input, 1), overide_address (input, ADDR_WIDTH) and overide_data_in (input, DATA_WIDTH), forming the bench preload write port.

Function
REQ-014 SHALL implement a 2^ADDR_WIDTH x DATA_WIDTH array; all addresses are valid, with no range checking.
REQ-015 SHALL use FSM states IDLE, WAIT, DONE.
REQ-016 SHALL accept a request in IDLE when Mem_enable512x32=1 and exactly one of Mem_Read/Mem_Write is 1; it SHALL latch address, type and write data at that edge.
REQ-017 SHALL, in IDLE with Mem_enable512x32=1 and both Mem_Read=Mem_Write=1, pulse Mem_error for one cycle, perform no access and stay in IDLE.
REQ-018 SHALL ignore requests while in WAIT or DONE; the latched request is not altered.
REQ-019 SHALL, without MEM_WAIT_STATES_EN, go IDLE->DONE on the accepting edge.
REQ-020 SHALL, in DONE, assert Mem_ready for exactly one cycle, then go to IDLE.
REQ-021 SHALL commit a write to the array on the edge that enters DONE.
REQ-022 SHALL load Mem_data_out from the array on the edge that enters DONE for a read, and hold it until the next completed read.
REQ-023 SHALL give writes no effect on Mem_data_out.
REQ-024 SHALL write overide_data_in to overide_address on every edge with mem_overide=1, in any state.
REQ-025 SHALL not accept requests while mem_overide=1.
REQ-026 SHALL hold an in-flight access in its current state (no commit, no Mem_ready) while mem_overide=1, and resume when it drops.
REQ-027 SHALL, when override and a commit target the same address on the same edge, let the override win.
REQ-028 SHALL permit back-to-back requests: a new request is accepted in the first IDLE cycle after DONE.

Reset
REQ-029 SHALL, with clear=0, immediately force FSM=IDLE, Mem_data_out=0, Mem_ready=0, Mem_error=0, and discard the latched request.
REQ-030 SHALL let a reset in WAIT or DONE abort the access: no array write and no Mem_ready.
REQ-031 SHALL not reset array contents.

Configuration
REQ-032 SHALL support macro MEM_WAIT_STATES_EN, which when defined routes IDLE->WAIT on acceptance.
REQ-033 SHALL, under MEM_WAIT_STATES_EN, stay in WAIT for WAIT_CYCLES cycles, counted by a down-counter, then go to DONE; WAIT_CYCLES=0 behaves as undefined.
REQ-034 SHALL, when MEM_WAIT_STATES_EN is undefined, contain no WAIT state and no counter logic, giving a fixed latency of one cycle from acceptance to Mem_ready.

Structure
REQ-035 SHALL place the state encoding (IDLE/WAIT/DONE) and the default widths (32/9) in shared package mem_pkg.
REQ-036 SHALL use sub-module mem_wait_counter (load, decrement, zero flag), instantiated only under MEM_WAIT_STATES_EN.

Verification
REQ-037 SHALL cover preload via override: addr 0=0x18900001, addr 500=0x00000014; reads of 0 and 500 return those values with Mem_ready one cycle after acceptance (macro off), or 1+WAIT_CYCLES=3 cycles (macro on, WAIT_CYCLES=2).
REQ-038 SHALL cover a write of 0xDEADBEEF to addr 511 then a read of 511: 0xDEADBEEF is returned, and Mem_data_out is unchanged by the write.
REQ-039 SHALL cover Mem_Read=Mem_Write=1 with enable: a one-cycle Mem_error, no Mem_ready, and array unchanged.
REQ-040 SHALL cover clear=0 driven mid-WAIT on a write of 0x12345678 to addr 7: addr 7 keeps its old value, Mem_ready never pulses, and outputs are 0.
REQ-041 SHALL cover mem_overide=1 for 3 cycles during an in-flight read of addr 5 while override writes 0xA5A5A5A5 to addr 5: the read completes after override drops and returns 0xA5A5A5A5.
